park_occupancy_ctr: RTL and testbench
=====================================

Name: park_occupancy_ctr

Overview:
Parametrised multi-lane successor to the single-lane car-park counter. Each lane has an a/b sensor pair and a direction-detection FSM that emits one-cycle entry and exit pulses. A shared occupancy counter sums all lanes' pulses each cycle, saturates at 0 and CAPACITY, and reports full, empty and sticky error flags. Sits between the sensor stimulus and the scoreboard in the lab top level.

Parameters:
N_LANES, 2, number of independent sensor pairs / lanes
CNT_W, 4, occupancy counter width in bits
CAPACITY, 15, maximum occupancy; must satisfy 1 <= CAPACITY <= 2**CNT_W-1

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
a  input  N_LANES  per-lane outer sensor; synchronous to clk, no synchroniser inside
b  input  N_LANES  per-lane inner sensor; synchronous to clk
clr_err  input  1  clears ovf_err/unf_err on next edge
inc  output  N_LANES  per-lane one-cycle entry pulse
dec  output  N_LANES  per-lane one-cycle exit pulse
count  output  CNT_W  current occupancy
full  output  1  count == CAPACITY
empty  output  1  count == 0
ovf_err  output  1  sticky: an increment was clipped at CAPACITY
unf_err  output  1  sticky: a decrement was clipped at 0

Behaviour:
- Reset (synchronous, priority over all else): all lane FSMs go to IDLE; inc=0, dec=0, count=0, ovf_err=0, unf_err=0. Hence empty=1, full=0. Reset mid-sequence discards the partial sequence and produces no pulse.
- Lane FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3. {a,b} is sampled each edge.
- IDLE: 10->EN1, 01->EX1, 00/11->IDLE.
- EN1: 10 stay, 11->EN2, 00->IDLE (abort), 01->IDLE.
- EN2: 11 stay, 01->EN3, 10->EN1 (backing out), 00->IDLE.
- EN3: 01 stay, 11->EN2, 00->IDLE with entry event, 10->IDLE.
- EX1/EX2/EX3 mirror EN1-EN3 with a and b swapped. Sequence 01->11->10->00 is an exit event.
- Pulse timing: inc[i]/dec[i] are registered. Each is high for exactly one cycle after the edge that samples the terminating 00. Aborted or illegal sequences never pulse. inc[i] and dec[i] are never high together.
- Counter: at each edge, delta = popcount(inc) - popcount(dec), range -N_LANES..+N_LANES, computed in signed width CNT_W+2.
  - next = count + delta, clamped to [0, CAPACITY].
  - count updates on the edge after the pulses are visible. Total latency from the final 00 sample to the count change is 2 edges.
- Simultaneous events: an entry on one lane and an exit on another in the same cycle net to zero; count is unchanged and no error is raised.
- Saturation: if count+delta > CAPACITY, count=CAPACITY and ovf_err sets. If count+delta < 0, count=0 and unf_err sets.
- Error flags: sticky until clr_err or reset. If clr_err coincides with a new clip event, the set wins.
- full/empty are combinational decodes of the count register.

Decomposition:
- Package park_pkg: lane state enum (lane_state_t, 3-bit), sensor encoding constants (AB_IDLE=2'b00, AB_A=2'b10, AB_AB=2'b11, AB_B=2'b01).
- Sub-module lane_dir_fsm (ports: clk, reset, a, b, inc, dec), instantiated N_LANES times in a generate loop.
- Popcount, clamp and flag logic live in the top module.

Test Plan:
- Lane0 drives 00,10,11,01,00 at one value per cycle from reset -> inc[0]=1 for one cycle, 1 cycle after the 00 sample; count 0->1 on the next edge; empty falls.
- Lane1 drives 10,11,10,00 (backs out) and lane0 drives 10,00 (abort) -> no inc/dec pulses; count holds at 1.
- With count=5, lane0 completes an entry and lane1 completes an exit on the same cycle -> inc=01, dec=10; count stays 5; no errors.
- Drive 15 entries, then two lanes enter simultaneously -> count saturates at 15, full=1, ovf_err=1. clr_err for 1 cycle -> ovf_err=0 while count stays 15.
- From count=0, lane0 completes an exit -> dec[0] pulses, count stays 0, unf_err=1.
- Assert reset while lane0 is in EN2 with count=3 -> next cycle count=0 and FSM is IDLE. Releasing the sensors to 01,00 afterwards produces no pulse.

Source files
------------

// File: rtl/park_pkg.sv
// Shared types and sensor encodings for the multi-lane car-park occupancy counter.
package park_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } lane_state_t;

  // {a,b} sensor pair encodings
  localparam logic [1:0] AB_IDLE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_AB   = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

endpackage

// File: rtl/park_occupancy_ctr_if.sv
// Sensor inputs, per-lane pulses and occupancy status of the car-park counter.
interface park_occupancy_ctr_if #(
  parameter int N_LANES = 2,
  parameter int CNT_W   = 4
);
  logic [N_LANES-1:0] a;
  logic [N_LANES-1:0] b;
  logic               clr_err;
  logic [N_LANES-1:0] inc;
  logic [N_LANES-1:0] dec;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               ovf_err;
  logic               unf_err;

  modport master (
    output a, b, clr_err,
    input  inc, dec, count, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  a, b, clr_err,
    output inc, dec, count, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/lane_dir_fsm.sv
// Per-lane direction detector: a->ab->b->idle is an entry, b->ab->a->idle an exit.
module lane_dir_fsm
  import park_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec
);

  lane_state_t state;
  logic [1:0]  ab;

  assign ab = {a, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      inc   <= 1'b0;
      dec   <= 1'b0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state)
        IDLE: begin
          if (ab == AB_A)      state <= EN1;
          else if (ab == AB_B) state <= EX1;
        end
        EN1: begin
          if (ab == AB_AB)     state <= EN2;
          else if (ab != AB_A) state <= IDLE;
        end
        EN2: begin
          if (ab == AB_B)       state <= EN3;
          else if (ab == AB_A)  state <= EN1;
          else if (ab != AB_AB) state <= IDLE;
        end
        EN3: begin
          if (ab == AB_AB)     state <= EN2;
          else if (ab != AB_B) begin
            state <= IDLE;
            inc   <= (ab == AB_IDLE);
          end
        end
        EX1: begin
          if (ab == AB_AB)     state <= EX2;
          else if (ab != AB_B) state <= IDLE;
        end
        EX2: begin
          if (ab == AB_A)       state <= EX3;
          else if (ab == AB_B)  state <= EX1;
          else if (ab != AB_AB) state <= IDLE;
        end
        EX3: begin
          if (ab == AB_AB)     state <= EX2;
          else if (ab != AB_A) begin
            state <= IDLE;
            dec   <= (ab == AB_IDLE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/park_occupancy_ctr.sv
// Multi-lane car-park occupancy counter: lane detectors feed a shared saturating counter.
module park_occupancy_ctr
  import park_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CNT_W    = 4,
  parameter int CAPACITY = 15
) (
  input logic                  clk,
  input logic                  reset,
  park_occupancy_ctr_if.slave  bus
);

  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [N_LANES-1:0]    inc_v, dec_v;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_q, unf_q;
  logic [SW-1:0]         n_inc, n_dec;
  logic signed [SW-1:0]  delta, sum;
  logic                  ovf_hit, unf_hit;
  logic [CNT_W-1:0]      cnt_nxt;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_dir_fsm u_fsm (
      .clk   (clk),
      .reset (reset),
      .a     (bus.a[i]),
      .b     (bus.b[i]),
      .inc   (inc_v[i]),
      .dec   (dec_v[i])
    );
  end

  // Net change from the registered pulses, then clamp into [0, CAPACITY]
  always_comb begin
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_inc = n_inc + SW'(inc_v[i]);
      n_dec = n_dec + SW'(dec_v[i]);
    end
    delta   = $signed(n_inc - n_dec);
    sum     = $signed({2'b00, cnt}) + delta;
    ovf_hit = (sum > CAP_S);
    unf_hit = (sum < 0);
    if (ovf_hit)      cnt_nxt = CAP_S[CNT_W-1:0];
    else if (unf_hit) cnt_nxt = '0;
    else              cnt_nxt = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      // a fresh clip outranks a concurrent clear
      ovf_q <= (ovf_q & ~bus.clr_err) | ovf_hit;
      unf_q <= (unf_q & ~bus.clr_err) | unf_hit;
    end
  end

  assign bus.inc     = inc_v;
  assign bus.dec     = dec_v;
  assign bus.count   = cnt;
  assign bus.full    = (cnt == CAP_S[CNT_W-1:0]);
  assign bus.empty   = (cnt == '0);
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule

// File: tb/tb_park_occupancy_ctr.sv
// Directed vector bench for park_occupancy_ctr with two lanes and a 4-bit counter.
module tb_park_occupancy_ctr;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   sn = 0;

  always #5 clk = ~clk;

  park_occupancy_ctr_if #(.N_LANES(2), .CNT_W(4)) bus ();

  park_occupancy_ctr #(.N_LANES(2), .CNT_W(4), .CAPACITY(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       rst;
    logic       clr;
    logic [1:0] ab0;
    logic [1:0] ab1;
    logic [1:0] inc;
    logic [1:0] dec;
    logic [3:0] cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  function automatic vec_t V(logic rst, logic clr, logic [1:0] ab0, logic [1:0] ab1,
                             logic [1:0] inc, logic [1:0] dec, logic [3:0] cnt,
                             logic ovf, logic unf);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ab0 = ab0; v.ab1 = ab1;
    v.inc = inc; v.dec = dec; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, sn, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare every output just after the edge
  task automatic step(input vec_t v);
    reset           = v.rst;
    bus.clr_err     = v.clr;
    bus.a           = {v.ab1[1], v.ab0[1]};
    bus.b           = {v.ab1[0], v.ab0[0]};
    @(posedge clk);
    #1;
    chk("inc",     8'(bus.inc),     8'(v.inc));
    chk("dec",     8'(bus.dec),     8'(v.dec));
    chk("count",   8'(bus.count),   8'(v.cnt));
    chk("full",    8'(bus.full),    8'(v.cnt == 4'd15));
    chk("empty",   8'(bus.empty),   8'(v.cnt == 4'd0));
    chk("ovf_err", 8'(bus.ovf_err), 8'(v.ovf));
    chk("unf_err", 8'(bus.unf_err), 8'(v.unf));
    sn++;
  endtask

  task automatic entry_both(input logic [3:0] c0, input logic [3:0] c1,
                            input logic o0, input logic o1);
    step(V(0, 0, 2'b10, 2'b10, 2'b00, 2'b00, c0, o0, 0));
    step(V(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, c0, o0, 0));
    step(V(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, c0, o0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, c0, o0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, c1, o1, 0));
  endtask

  vec_t tbl [27];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.clr_err = 1'b0; bus.a = '0; bus.b = '0;

    // reset, then single entry on lane 0
    tbl[0]  = V(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    tbl[2]  = V(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    tbl[3]  = V(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    tbl[4]  = V(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    tbl[5]  = V(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0);
    tbl[6]  = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    // lane 0 aborts, lane 1 backs out
    tbl[7]  = V(0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 1, 0, 0);
    tbl[8]  = V(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0);
    tbl[9]  = V(0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 0);
    tbl[10] = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    tbl[11] = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    // two simultaneous entries, twice: 1 -> 3 -> 5
    tbl[12] = V(0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 1, 0, 0);
    tbl[13] = V(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0);
    tbl[14] = V(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0);
    tbl[15] = V(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 0);
    tbl[16] = V(0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 3, 0, 0);
    tbl[17] = V(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 3, 0, 0);
    tbl[18] = V(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 3, 0, 0);
    tbl[19] = V(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 3, 0, 0);
    tbl[20] = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5, 0, 0);
    // lane 0 enters while lane 1 exits: net zero
    tbl[21] = V(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 5, 0, 0);
    tbl[22] = V(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 5, 0, 0);
    tbl[23] = V(0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 5, 0, 0);
    tbl[24] = V(0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 5, 0, 0);
    tbl[25] = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5, 0, 0);
    tbl[26] = V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 27; i++) step(tbl[i]);

    // fill to capacity exactly, then overflow by two
    for (int k = 0; k < 5; k++) entry_both(4'(5 + 2 * k), 4'(7 + 2 * k), 0, 0);
    entry_both(15, 15, 0, 1);
    step(V(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 15, 0, 0));
    // clip coinciding with clr_err: the set wins
    step(V(0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 15, 0, 0));
    step(V(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 15, 0, 0));
    step(V(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 15, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 15, 0, 0));
    step(V(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 15, 1, 0));
    step(V(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 15, 0, 0));

    // reset, then an exit from empty underflows
    step(V(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
    step(V(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));

    // reach 3, reset with lane 0 in EN2, then release sensors
    entry_both(0, 2, 0, 0);
    step(V(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2, 0, 0));
    step(V(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2, 0, 0));
    step(V(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2, 0, 0));
    step(V(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3, 0, 0));
    step(V(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 3, 0, 0));
    step(V(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    // lane 0 still counts a clean entry afterwards
    step(V(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0));
    step(V(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
